// File: rtl/trng_vn_packer.sv
// Von Neumann debiaser and MSB-first byte packer feeding the TRNG byte FIFO,
// with a repetition-count health alarm and a saturating dropped-byte counter.
module trng_vn_packer #(
    parameter int unsigned REP_LIMIT = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       raw_bit,
    input  logic       raw_valid,
    input  logic       fifo_full,
    output logic       wr,
    output logic [7:0] data_out,
    output logic       alarm,
    output logic [7:0] overflow_cnt
);

    localparam logic [7:0] REP_LIMIT_W = 8'(REP_LIMIT);

    logic       half_q,    half_d;
    logic       first_q,   first_d;
    logic [2:0] cnt_q,     cnt_d;
    logic [6:0] sr_q,      sr_d;
    logic [7:0] data_q,    data_d;
    logic       pending_q, pending_d;
    logic       alarm_q,   alarm_d;
    logic [7:0] ovf_q,     ovf_d;
    logic [7:0] run_q,     run_d;
    logic       last_q,    last_d;

    logic       accept;
    logic       byte_done;
    logic [7:0] new_byte;

    assign accept       = raw_valid & en & ~alarm_q;
    assign wr           = pending_q & ~fifo_full;
    assign data_out     = data_q;
    assign alarm        = alarm_q;
    assign overflow_cnt = ovf_q;

    always_comb begin
        half_d    = half_q;
        first_d   = first_q;
        cnt_d     = cnt_q;
        sr_d      = sr_q;
        data_d    = data_q;
        pending_d = pending_q;
        alarm_d   = alarm_q;
        ovf_d     = ovf_q;
        run_d     = run_q;
        last_d    = last_q;
        byte_done = 1'b0;
        new_byte  = 8'h00;

        if (!en) begin
            half_d = 1'b0;
        end

        if (accept) begin
            // Health test runs on raw samples, before any debiasing.
            run_d  = (raw_bit == last_q) ? run_q + 8'd1 : 8'd1;
            last_d = raw_bit;
            if (run_d == REP_LIMIT_W) begin
                alarm_d = 1'b1;
            end

            if (!half_q) begin
                first_d = raw_bit;
                half_d  = 1'b1;
            end else begin
                half_d = 1'b0;
                if (first_q != raw_bit) begin
                    sr_d  = {sr_q[5:0], first_q};
                    cnt_d = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        byte_done = 1'b1;
                        new_byte  = {sr_q, first_q};
                    end
                end
            end
        end

        if (wr) begin
            pending_d = 1'b0;
        end

        if (byte_done) begin
            if (!pending_q || wr) begin
                data_d    = new_byte;
                pending_d = 1'b1;
            end else if (ovf_q != 8'hFF) begin
                ovf_d = ovf_q + 8'd1;
            end
        end

        // A tripped alarm throws away whatever byte is waiting for the FIFO.
        if (alarm_d) begin
            pending_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            half_q    <= 1'b0;
            first_q   <= 1'b0;
            cnt_q     <= 3'd0;
            sr_q      <= 7'd0;
            data_q    <= 8'h00;
            pending_q <= 1'b0;
            alarm_q   <= 1'b0;
            ovf_q     <= 8'h00;
            run_q     <= 8'h00;
            last_q    <= 1'b0;
        end else begin
            half_q    <= half_d;
            first_q   <= first_d;
            cnt_q     <= cnt_d;
            sr_q      <= sr_d;
            data_q    <= data_d;
            pending_q <= pending_d;
            alarm_q   <= alarm_d;
            ovf_q     <= ovf_d;
            run_q     <= run_d;
            last_q    <= last_d;
        end
    end

endmodule

// File: tb/tb_trng_vn_packer.sv
// Directed bench for trng_vn_packer: one default-limit instance plus one with
// REP_LIMIT=4 sharing the same stimulus for the health-alarm case.
module tb_trng_vn_packer;

    logic       clk;
    logic       rst;
    logic       en;
    logic       raw_bit;
    logic       raw_valid;
    logic       fifo_full;
    logic       wr;
    logic [7:0] data_out;
    logic       alarm;
    logic [7:0] overflow_cnt;
    logic       wr4;
    logic [7:0] data_out4;
    logic       alarm4;
    logic [7:0] overflow_cnt4;

    int total;
    int bad;
    int wr_count;
    int wr4_count;
    int base;

    trng_vn_packer dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .raw_bit      (raw_bit),
        .raw_valid    (raw_valid),
        .fifo_full    (fifo_full),
        .wr           (wr),
        .data_out     (data_out),
        .alarm        (alarm),
        .overflow_cnt (overflow_cnt)
    );

    trng_vn_packer #(.REP_LIMIT(4)) dut4 (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .raw_bit      (raw_bit),
        .raw_valid    (raw_valid),
        .fifo_full    (fifo_full),
        .wr           (wr4),
        .data_out     (data_out4),
        .alarm        (alarm4),
        .overflow_cnt (overflow_cnt4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Count write strobes mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (wr === 1'b1) wr_count++;
        if (wr4 === 1'b1) wr4_count++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Drives one accepted-sample strobe per cycle, characters '0'/'1' in order.
    task automatic applyStimulus(input string s);
        for (int i = 0; i < s.len(); i++) begin
            raw_valid = 1'b1;
            raw_bit   = (s[i] == 8'h31);
            @(posedge clk);
            #1;
            raw_valid = 1'b0;
        end
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        wr_count  = 0;
        wr4_count = 0;
        rst       = 1'b0;
        en        = 1'b1;
        raw_bit   = 1'b0;
        raw_valid = 1'b0;
        fifo_full = 1'b0;

        #12;
        checkOutput("rst_wr", wr, 0);
        checkOutput("rst_data", data_out, 8'h00);
        checkOutput("rst_alarm", alarm, 0);
        checkOutput("rst_ovf", overflow_cnt, 8'h00);
        rst = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] clean 0xA5 byte");
        base = wr_count;
        applyStimulus("100110010110011");
        checkOutput("a5_no_early_wr", wr, 0);
        applyStimulus("0");
        checkOutput("a5_wr", wr, 1);
        checkOutput("a5_data", data_out, 8'hA5);
        @(posedge clk);
        #1;
        checkOutput("a5_wr_drop", wr, 0);
        checkOutput("a5_wr_count", wr_count - base, 1);

        $display("[TB] 0xA5 with discarded 00/11 pairs");
        base = wr_count;
        applyStimulus("1000011110000111010010110100");
        checkOutput("mix_no_early_wr", wr_count - base, 0);
        applyStimulus("10");
        checkOutput("mix_wr", wr, 1);
        checkOutput("mix_data", data_out, 8'hA5);
        @(posedge clk);
        #1;
        checkOutput("mix_wr_count", wr_count - base, 1);

        $display("[TB] back-pressure and overflow");
        base = wr_count;
        fifo_full = 1'b1;
        applyStimulus("0101101010100101");
        applyStimulus("1010010101011010");
        checkOutput("bp_wr_held", wr, 0);
        checkOutput("bp_ovf", overflow_cnt, 8'd1);
        checkOutput("bp_data", data_out, 8'h3C);
        checkOutput("bp_no_writes", wr_count - base, 0);
        fifo_full = 1'b0;
        #1;
        checkOutput("bp_release_wr", wr, 1);
        @(posedge clk);
        #1;
        checkOutput("bp_one_pulse", wr_count - base, 1);
        checkOutput("bp_wr_done", wr, 0);
        checkOutput("bp_data_kept", data_out, 8'h3C);

        $display("[TB] async reset mid-byte");
        applyStimulus("1001100101");
        #2;
        rst = 1'b0;
        #1;
        checkOutput("mid_rst_wr", wr, 0);
        checkOutput("mid_rst_data", data_out, 8'h00);
        checkOutput("mid_rst_ovf", overflow_cnt, 8'h00);
        checkOutput("mid_rst_alarm", alarm, 0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        @(posedge clk);
        #1;
        base = wr_count;
        applyStimulus("0110011010011001");
        checkOutput("post_rst_wr", wr, 1);
        checkOutput("post_rst_data", data_out, 8'h5A);
        @(posedge clk);
        #1;
        checkOutput("post_rst_count", wr_count - base, 1);

        $display("[TB] en low discards stored half");
        applyStimulus("1");
        en        = 1'b0;
        raw_valid = 1'b1;
        raw_bit   = 1'b0;
        @(posedge clk);
        #1;
        raw_valid = 1'b0;
        en        = 1'b1;
        applyStimulus("01");
        applyStimulus("01010110101010");
        checkOutput("en_wr", wr, 1);
        checkOutput("en_data", data_out, 8'h0F);
        @(posedge clk);
        #1;

        $display("[TB] repetition alarm, REP_LIMIT=4");
        rst = 1'b0;
        #2;
        rst = 1'b1;
        @(posedge clk);
        #1;
        fifo_full = 1'b1;
        applyStimulus("1001100101100110");
        checkOutput("al_pending_held", wr4, 0);
        checkOutput("al_data", data_out4, 8'hA5);
        applyStimulus("111");
        checkOutput("al_not_yet", alarm4, 0);
        applyStimulus("1");
        checkOutput("al_set", alarm4, 1);
        fifo_full = 1'b0;
        #1;
        checkOutput("al_wr_gone", wr4, 0);
        base = wr4_count;
        applyStimulus("10011001011001101001100101100110");
        repeat (3) @(posedge clk);
        #1;
        checkOutput("al_no_writes", wr4_count - base, 0);
        checkOutput("al_sticky", alarm4, 1);
        checkOutput("al_default_ok", alarm, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
